// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared defines for the fetch stage and its neighbours: the stall-bus width
// and codes used by the stall controller, plus the instruction address and
// instruction bus widths. FSM encodings are kept local to each module.
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

  localparam int StallBusW    = 2;
  localparam int InstAddrBusW = 32;
  localparam int InstBusW     = 32;

  // Stall codes driven by the stall controller.
  localparam logic [StallBusW-1:0] STALL_PASS = 2'b00;
  localparam logic [StallBusW-1:0] STALL_HOLD = 2'b01;
  localparam logic [StallBusW-1:0] STALL_BUBB = 2'b10;

endpackage : inst_fetch_pkg

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Instruction fetch stage over a byte-wide memory. It reads four consecutive
// bytes starting at the PC, assembles them little-endian into a 32-bit
// instruction, and presents the instruction to the IF/ID register until the
// stall controller lets it pass. A jump redirects the PC at any time and
// discards whatever fetch was in progress.
//
// Ports
//   clk        system clock, all state updates on its rising edge
//   rst        synchronous active-low reset
//   stall      IF-stage stall code (Pass/Hold/Bubb); only looked at in READY
//   jump_en    one-cycle redirect request, wins over stall and completion
//   jump_addr  redirect target PC
//   mem_din    read byte, valid one cycle after the matching mem_rd_en
//   mem_rd_en  byte read strobe
//   mem_addr   byte read address (driven to 0 while mem_rd_en is low)
//   pc_o       PC of the presented instruction
//   inst_o     assembled instruction
//   inst_valid inst_o/pc_o hold a complete instruction
//   stall_req  fetch in progress, IF/ID must not be passed
// -----------------------------------------------------------------------------
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [InstAddrBusW-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBusW-1:0]    stall,
  input  logic                    jump_en,
  input  logic [31:0]             jump_addr,
  input  logic [7:0]              mem_din,
  output logic                    mem_rd_en,
  output logic [31:0]             mem_addr,
  output logic [InstAddrBusW-1:0] pc_o,
  output logic [InstBusW-1:0]     inst_o,
  output logic                    inst_valid,
  output logic                    stall_req
);

  // S_IDLE only exists while reset is held: every output stays 0 there, and
  // the first cycle after reset releases is always the FETCH entry cycle.
  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_READY
  } state_e;

  localparam logic [2:0] ISSUE_DONE = 3'd4;

  state_e                  state_q,     state_d;
  logic [InstAddrBusW-1:0] pc_q,        pc_d;        // address being fetched
  logic [InstAddrBusW-1:0] pc_out_q,    pc_out_d;    // address of presented inst
  logic [InstBusW-1:0]     inst_q,      inst_d;
  logic [2:0]              issue_cnt_q, issue_cnt_d; // reads issued, 0..4
  logic [1:0]              lane_cnt_q,  lane_cnt_d;  // bytes captured, 0..3
  logic                    pending_q,   pending_d;   // a read is in flight

  always_comb begin
    // NOTE: every next-state variable and output takes a default before any
    // branch, so no path through this block can infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    pc_out_d    = pc_out_q;
    inst_d      = inst_q;
    issue_cnt_d = issue_cnt_q;
    lane_cnt_d  = lane_cnt_q;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    stall_req   = 1'b0;
    inst_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        stall_req = 1'b1;
        // Issue side: one byte per cycle until four reads are out.
        if (issue_cnt_q != ISSUE_DONE) begin
          mem_rd_en   = 1'b1;
          mem_addr    = pc_q + {29'd0, issue_cnt_q};
          issue_cnt_d = issue_cnt_q + 3'd1;
        end
        // Capture side: runs one cycle behind issue, gated by the pending
        // bit so data for a read cancelled by a jump or reset never lands.
        if (pending_q) begin
          inst_d[{lane_cnt_q, 3'b000} +: 8] = mem_din;
          lane_cnt_d                        = lane_cnt_q + 2'd1;
          if (lane_cnt_q == 2'd3) begin
            state_d  = S_READY;
            pc_out_d = pc_q;
          end
        end
      end

      S_READY: begin
        inst_valid = 1'b1;
        if (stall == STALL_PASS) begin
          state_d     = S_FETCH;
          pc_d        = pc_q + 32'd4;
          issue_cnt_d = '0;
          lane_cnt_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    pending_d = mem_rd_en;

    // A redirect overrides everything above, including a completing fetch
    // and a Pass in READY; the presented PC is left as it was.
    if (jump_en) begin
      state_d     = S_FETCH;
      pc_d        = jump_addr;
      pc_out_d    = pc_out_q;
      issue_cnt_d = '0;
      lane_cnt_d  = '0;
      pending_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample the
    // pre-edge values, independent of statement order.
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pc_out_q    <= '0;
      inst_q      <= '0;
      issue_cnt_q <= '0;
      lane_cnt_q  <= '0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_out_q    <= pc_out_d;
      inst_q      <= inst_d;
      issue_cnt_q <= issue_cnt_d;
      lane_cnt_q  <= lane_cnt_d;
      pending_q   <= pending_d;
    end
  end

  assign pc_o   = pc_out_q;
  assign inst_o = inst_q;

endmodule : inst_fetch

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Self-checking bench for inst_fetch. A byte memory (associative array,
// lazily filled with random bytes) answers reads one cycle late. Expected
// instructions are computed from the memory contents directly; expected
// PCs follow the redirect / advance-by-4 rules.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [1:0]  stall;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [7:0]  mem_din;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid;
  logic        stall_req;

  int vectors;
  int miscompares;

  logic [7:0]  mem [logic [31:0]];
  logic [31:0] addr_q [$];

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .mem_din    (mem_din),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .pc_o       (pc_o),
    .inst_o     (inst_o),
    .inst_valid (inst_valid),
    .stall_req  (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic logic [7:0] mb(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  // Little-endian word starting at pc, addresses wrapping at 2^32.
  function automatic logic [31:0] model_inst(input logic [31:0] pc);
    return {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
  endfunction

  // Memory answers one cycle after the strobe; garbage otherwise so that a
  // capture outside a real read shows up in inst_o.
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) mem_din <= mb(mem_addr);
    else                    mem_din <= 8'($urandom);
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From a FETCH entry sample, run until inst_valid (bounded), logging the
  // read addresses. n = cycles from FETCH entry to inst_valid.
  task automatic collect(input bit rand_stall, output int n);
    addr_q.delete();
    n = 0;
    while (inst_valid !== 1'b1 && n < 16) begin
      if (mem_rd_en === 1'b1) addr_q.push_back(mem_addr);
      if (rand_stall) stall = 2'($urandom_range(0, 2));
      tick();
      n++;
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b0; stall = STALL_PASS; jump_en = 1'b0; jump_addr = '0;
    tick(); tick();
    vectors++;
    if ({inst_valid, stall_req, mem_rd_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got valid/req/rd=%b want 000", {inst_valid, stall_req, mem_rd_en});
    end
    vectors++;
    if ({pc_o, inst_o} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: got pc_o=%h inst_o=%h want 0/0", pc_o, inst_o);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b1 || mem_addr !== RESET_PC || stall_req !== 1'b1 || inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got rd=%b addr=%h req=%b valid=%b want 1 %h 1 0",
               mem_rd_en, mem_addr, stall_req, inst_valid, RESET_PC);
    end
  endtask

  task automatic test_basic();
    int n;
    collect(1'b0, n);
    vectors++;
    if (n !== 5) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d cycles want 5", n);
    end
    vectors++;
    if (addr_q.size() !== 4) begin
      miscompares++;
      $display("FAIL basic_reads: got %0d reads want 4", addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (addr_q[i] !== 32'(i)) begin
          miscompares++;
          $display("FAIL basic_addr%0d: got %h want %h", i, addr_q[i], 32'(i));
        end
      end
    end
    vectors++;
    if (inst_o !== 32'h0000_0513 || pc_o !== 32'h0) begin
      miscompares++;
      $display("FAIL basic_inst: got inst=%h pc=%h want 00000513/0", inst_o, pc_o);
    end
    vectors++;
    if (stall_req !== 1'b0 || mem_rd_en !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ready: got req=%b rd=%b want 0 0", stall_req, mem_rd_en);
    end
  endtask

  task automatic test_hold();
    int n;
    for (int h = 0; h < 3; h++) begin
      stall = (h == 1) ? STALL_BUBB : STALL_HOLD;
      tick();
      vectors++;
      if (inst_o !== 32'h0000_0513 || pc_o !== 32'h0 || inst_valid !== 1'b1 ||
          mem_rd_en !== 1'b0 || stall_req !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_%0d: got inst=%h pc=%h valid=%b rd=%b req=%b want 00000513 0 1 0 0",
                 h, inst_o, pc_o, inst_valid, mem_rd_en, stall_req);
      end
    end
    stall = STALL_PASS;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h4) begin
      miscompares++;
      $display("FAIL hold_pass: got rd=%b addr=%h want 1 00000004", mem_rd_en, mem_addr);
    end
    collect(1'b1, n);
    vectors++;
    if (n !== 5 || pc_o !== 32'h4 || inst_o !== model_inst(32'h4)) begin
      miscompares++;
      $display("FAIL hold_next: got n=%0d pc=%h inst=%h want 5 00000004 %h",
               n, pc_o, inst_o, model_inst(32'h4));
    end
    stall = STALL_PASS;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h8) begin
      miscompares++;
      $display("FAIL hold_next_fetch: got rd=%b addr=%h want 1 00000008", mem_rd_en, mem_addr);
    end
  endtask

  task automatic test_jump_mid();
    int n;
    tick(); tick();
    vectors++;
    if (mem_addr !== 32'hA) begin
      miscompares++;
      $display("FAIL jmid_byte2: got addr=%h want 0000000a", mem_addr);
    end
    jump_en = 1'b1; jump_addr = 32'h100;
    tick();
    jump_en = 1'b0;
    vectors++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL jmid_restart: got rd=%b addr=%h want 1 00000100", mem_rd_en, mem_addr);
    end
    collect(1'b1, n);
    vectors++;
    if (n !== 5 || addr_q.size() !== 4) begin
      miscompares++;
      $display("FAIL jmid_latency: got n=%0d reads=%0d want 5 4", n, addr_q.size());
    end else if (addr_q[3] !== 32'h103) begin
      miscompares++;
      $display("FAIL jmid_last_addr: got %h want 00000103", addr_q[3]);
    end
    vectors++;
    if (pc_o !== 32'h100 || inst_o !== model_inst(32'h100)) begin
      miscompares++;
      $display("FAIL jmid_inst: got pc=%h inst=%h want 00000100 %h", pc_o, inst_o, model_inst(32'h100));
    end
  endtask

  task automatic test_jump_complete();
    int n;
    logic [31:0] tgt;
    stall = STALL_PASS;
    tick();             // FETCH entry at 0x104
    repeat (4) tick();  // completion cycle
    vectors++;
    if (mem_rd_en !== 1'b0 || inst_valid !== 1'b0 || stall_req !== 1'b1) begin
      miscompares++;
      $display("FAIL jcomp_pre: got rd=%b valid=%b req=%b want 0 0 1", mem_rd_en, inst_valid, stall_req);
    end
    tgt = $urandom;
    jump_en = 1'b1; jump_addr = tgt;
    tick();
    jump_en = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== tgt) begin
      miscompares++;
      $display("FAIL jcomp_discard: got valid=%b rd=%b addr=%h want 0 1 %h", inst_valid, mem_rd_en, mem_addr, tgt);
    end
    collect(1'b1, n);
    vectors++;
    if (n !== 5 || pc_o !== tgt || inst_o !== model_inst(tgt)) begin
      miscompares++;
      $display("FAIL jcomp_inst: got n=%0d pc=%h inst=%h want 5 %h %h", n, pc_o, inst_o, tgt, model_inst(tgt));
    end
    // Jump in READY together with Pass: the jump target wins over pc+4.
    tgt = $urandom;
    jump_en = 1'b1; jump_addr = tgt; stall = STALL_PASS;
    tick();
    jump_en = 1'b0;
    vectors++;
    if (inst_valid !== 1'b0 || mem_addr !== tgt) begin
      miscompares++;
      $display("FAIL jready_pass: got valid=%b addr=%h want 0 %h", inst_valid, mem_addr, tgt);
    end
    collect(1'b1, n);
  endtask

  task automatic test_wrap();
    int n;
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    tick();
    jump_en = 1'b0;
    collect(1'b0, n);
    vectors++;
    if (addr_q.size() !== 4) begin
      miscompares++;
      $display("FAIL wrap_reads: got %0d reads want 4", addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (addr_q[i] !== 32'hFFFF_FFFC + 32'(i)) begin
          miscompares++;
          $display("FAIL wrap_addr%0d: got %h want %h", i, addr_q[i], 32'hFFFF_FFFC + 32'(i));
        end
      end
    end
    vectors++;
    if (pc_o !== 32'hFFFF_FFFC || inst_o !== model_inst(32'hFFFF_FFFC)) begin
      miscompares++;
      $display("FAIL wrap_inst: got pc=%h inst=%h want fffffffc %h", pc_o, inst_o, model_inst(32'hFFFF_FFFC));
    end
    stall = STALL_PASS;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next: got rd=%b addr=%h want 1 00000000", mem_rd_en, mem_addr);
    end
    collect(1'b0, n);
    vectors++;
    if (n !== 5 || pc_o !== 32'h0 || inst_o !== 32'h0000_0513) begin
      miscompares++;
      $display("FAIL wrap_zero: got n=%0d pc=%h inst=%h want 5 0 00000513", n, pc_o, inst_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    stall = STALL_PASS;
    tick();          // FETCH at 0x4
    tick(); tick();  // mid-fetch
    rst = 1'b0;
    tick();
    vectors++;
    if ({inst_valid, stall_req, mem_rd_en} !== 3'b000 || pc_o !== 32'h0 ||
        inst_o !== 32'h0 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_zero: got valid=%b req=%b rd=%b pc=%h inst=%h addr=%h want all 0",
               inst_valid, stall_req, mem_rd_en, pc_o, inst_o, mem_addr);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (mem_rd_en !== 1'b1 || mem_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL rmid_restart: got rd=%b addr=%h want 1 %h", mem_rd_en, mem_addr, RESET_PC);
    end
    collect(1'b1, n);
    vectors++;
    if (n !== 5 || pc_o !== RESET_PC || inst_o !== 32'h0000_0513) begin
      miscompares++;
      $display("FAIL rmid_inst: got n=%0d pc=%h inst=%h want 5 %h 00000513", n, pc_o, inst_o, RESET_PC);
    end
  endtask

  // Random mix of holds, passes, READY jumps and mid-fetch jumps. Starts and
  // ends each iteration in READY presenting exp_pc.
  task automatic test_random();
    int          n;
    int          choice;
    logic [31:0] exp_pc;
    logic [31:0] next_pc;
    exp_pc = RESET_PC;
    for (int it = 0; it < 40; it++) begin
      choice = $urandom_range(0, 3);
      case (choice)
        0: begin
          for (int h = 0; h < int'($urandom_range(1, 3)); h++) begin
            stall = ($urandom_range(0, 1) == 0) ? STALL_HOLD : STALL_BUBB;
            tick();
            vectors++;
            if (inst_valid !== 1'b1 || pc_o !== exp_pc || inst_o !== model_inst(exp_pc)) begin
              miscompares++;
              $display("FAIL rand_hold it%0d: got valid=%b pc=%h inst=%h want 1 %h %h",
                       it, inst_valid, pc_o, inst_o, exp_pc, model_inst(exp_pc));
            end
          end
          stall = STALL_PASS;
          tick();
          next_pc = exp_pc + 32'd4;
        end
        1: begin
          next_pc = $urandom;
          jump_en = 1'b1; jump_addr = next_pc; stall = STALL_PASS;
          tick();
          jump_en = 1'b0;
        end
        2: begin
          stall = STALL_PASS;
          tick();
          for (int c = 0; c < int'($urandom_range(0, 4)); c++) begin
            stall = 2'($urandom_range(0, 2));
            tick();
          end
          next_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
          jump_en = 1'b1; jump_addr = next_pc;
          tick();
          jump_en = 1'b0;
        end
        default: begin
          stall = STALL_PASS;
          tick();
          next_pc = exp_pc + 32'd4;
        end
      endcase
      vectors++;
      if (mem_rd_en !== 1'b1 || mem_addr !== next_pc || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_entry it%0d: got rd=%b addr=%h valid=%b want 1 %h 0",
                 it, mem_rd_en, mem_addr, inst_valid, next_pc);
      end
      collect(1'b1, n);
      vectors++;
      if (n !== 5 || pc_o !== next_pc || inst_o !== model_inst(next_pc)) begin
        miscompares++;
        $display("FAIL rand_inst it%0d: got n=%0d pc=%h inst=%h want 5 %h %h",
                 it, n, pc_o, inst_o, next_pc, model_inst(next_pc));
      end
      vectors++;
      if (addr_q.size() !== 4 || addr_q[0] !== next_pc || addr_q[3] !== next_pc + 32'd3) begin
        miscompares++;
        $display("FAIL rand_addrs it%0d: got %0d reads first=%h want 4 reads from %h",
                 it, addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : 32'h0, next_pc);
      end
      exp_pc = next_pc;
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    stall       = STALL_PASS;
    jump_en     = 1'b0;
    jump_addr   = '0;
    mem_din     = '0;
    mem[32'h0] = 8'h13;
    mem[32'h1] = 8'h05;
    mem[32'h2] = 8'h00;
    mem[32'h3] = 8'h00;

    test_reset();
    test_basic();
    test_hold();
    test_jump_mid();
    test_jump_complete();
    test_wrap();
    test_reset_mid();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule : tb_inst_fetch

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the fetch address after reset.
REQ-002 SHALL have port clk  input  1  meaning the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning synchronous, active-low reset.
REQ-004 SHALL have port stall  input  StallBus (2)  meaning the IF-stage stall code from the stall controller (Pass/Hold/Bubb).
REQ-005 SHALL have port jump_en  input  1  meaning branch/jump redirect request, valid for one cycle.
REQ-006 SHALL have port jump_addr  input  32  meaning the redirect target PC.
REQ-007 SHALL have port mem_din  input  8  meaning the read byte, valid one cycle after the matching mem_rd_en.
REQ-008 SHALL have port mem_rd_en  output  1  meaning the byte read strobe.
REQ-009 SHALL have port mem_addr  output  32  meaning the byte read address.
REQ-010 SHALL have port pc_o  output  InstAddrBus (32)  meaning the PC of the presented instruction, driving the IF/ID register pc input.
REQ-011 SHALL have port inst_o  output  InstBus (32)  meaning the assembled instruction, driving the IF/ID register instruction input.
REQ-012 SHALL have port inst_valid  output  1  meaning inst_o/pc_o hold a complete instruction.
REQ-013 SHALL have port stall_req  output  1  meaning fetch in progress; the stall controller must not pass IF/ID.

Function
REQ-014 SHALL implement the FSM states FETCH (issuing and collecting bytes) and READY (presenting an instruction).
REQ-015 SHALL, in FETCH, issue reads to pc+0, pc+1, pc+2 and pc+3 on four consecutive cycles (mem_rd_en=1), with addresses taken modulo 2^32.
REQ-016 SHALL capture mem_din one cycle after each issue into byte lane k of inst_o (little-endian: pc+0 goes to bits 7:0).
REQ-017 SHALL enter READY on the cycle after the fourth byte is captured: 5 cycles from FETCH entry to inst_valid=1.
REQ-018 SHALL drive stall_req=1 and inst_valid=0 throughout FETCH, and stall_req=0 and inst_valid=1 in READY.
REQ-019 SHALL, in READY with stall==Pass, set pc<=pc+4 (wrapping at 2^32) and enter FETCH next cycle.
REQ-020 SHALL, in READY with stall==Hold or Bubb, keep pc_o, inst_o and inst_valid unchanged.
REQ-021 SHALL, on jump_en=1 in any state, set pc<=jump_addr, discard all collected bytes and any outstanding read, and enter FETCH next cycle with a lane count of 0.
REQ-022 SHALL give jump_en priority over stall and over completion: a jump in the completion cycle or in READY+Pass discards that instruction.
REQ-023 SHALL ignore mem_din arriving for a read issued before a jump; capture SHALL be gated by a registered pending bit that is cleared on jump.
REQ-024 SHALL drive mem_rd_en=0 in READY; mem_addr SHALL be don't-care when mem_rd_en=0.
REQ-025 SHALL ignore stall during FETCH; progress depends only on the byte sequence and jump_en.

Reset
REQ-026 SHALL, when rst=0 at a clock edge, set pc=RESET_PC, clear the lane count and pending bit, and clear inst_o=0, pc_o=0 and inst_valid=0.
REQ-027 SHALL enter FETCH in the first cycle after reset deasserts, issuing to RESET_PC.
REQ-028 SHALL abort any in-progress fetch on reset mid-fetch and ignore late mem_din.

Structure
REQ-029 SHALL take the StallBus width, the codes Pass=2'b00, Hold=2'b01 and Bubb=2'b10, InstAddrBus and InstBus from the shared defines package; the FSM state encoding SHALL stay local.
REQ-030 SHALL be implemented as a single module with no sub-module; the byte assembler SHALL remain inline.

Verification
REQ-031 SHALL verify: reset, memory bytes 13,05,00,00 at 0x0..0x3, stall=Pass -> inst_valid rises 5 cycles after FETCH entry, inst_o=32'h0000_0513, pc_o=0, next fetch at 0x4.
REQ-032 SHALL verify: stall=Hold for 3 cycles in READY -> inst_o, pc_o and inst_valid stable, mem_rd_en=0; on Pass, pc_o advances to 0x4.
REQ-033 SHALL verify: jump_en with jump_addr=0x100 during byte 2 of a fetch at 0x8 -> the stale byte is ignored, reads restart at 0x100, and the first valid pc_o is 0x100.
REQ-034 SHALL verify: jump_en in the completion cycle -> no inst_valid pulse for the old PC, fetch restarts at the jump target.
REQ-035 SHALL verify: pc=32'hFFFF_FFFC with Pass -> byte addresses FFFF_FFFC..FFFF_FFFF, then the next pc is 0x0.
REQ-036 SHALL verify: rst asserted mid-fetch -> the next cycle has all outputs 0, and the fetch restarts at RESET_PC after release.
